ahbl_arbiter: RTL and testbench

Multi-master AHB-Lite arbiter that shares one downstream AHB-Lite port (a crossbar source port) between N_PORTS upstream masters, e.g. the CPU plus a DMA or display fetch engine. Each upstream port registers its address phase into a one-entry buffer. Buffered requests are issued downstream in round-robin order, with hmastlock honoured. Write data, read data and responses are routed by a registered data-phase owner.

---
 rtl/ahbl_arbiter_if.sv | 53 +++++
 rtl/ahbl_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_ahbl_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahbl_arbiter_if.sv
// Bus bundle for ahbl_arbiter: N_PORTS flattened upstream AHB-Lite ports plus one
// downstream port. Upstream port i occupies slice [i*W +: W] of each vector.
interface ahbl_arbiter_if #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned W_ADDR  = 32,
  parameter int unsigned W_DATA  = 32
);
  logic [N_PORTS-1:0]        src_hready;
  logic [N_PORTS-1:0]        src_hready_resp;
  logic [N_PORTS-1:0]        src_hresp;
  logic [N_PORTS*W_ADDR-1:0] src_haddr;
  logic [N_PORTS-1:0]        src_hwrite;
  logic [N_PORTS*2-1:0]      src_htrans;
  logic [N_PORTS*3-1:0]      src_hsize;
  logic [N_PORTS*3-1:0]      src_hburst;
  logic [N_PORTS*4-1:0]      src_hprot;
  logic [N_PORTS-1:0]        src_hmastlock;
  logic [N_PORTS*W_DATA-1:0] src_hwdata;
  logic [N_PORTS*W_DATA-1:0] src_hrdata;

  logic                      dst_hready;
  logic                      dst_hready_resp;
  logic                      dst_hresp;
  logic [W_ADDR-1:0]         dst_haddr;
  logic                      dst_hwrite;
  logic [1:0]                dst_htrans;
  logic [2:0]                dst_hsize;
  logic [2:0]                dst_hburst;
  logic [3:0]                dst_hprot;
  logic                      dst_hmastlock;
  logic [W_DATA-1:0]         dst_hwdata;
  logic [W_DATA-1:0]         dst_hrdata;

  // Arbiter view
  modport slave (
    input  src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
           src_hprot, src_hmastlock, src_hwdata,
           dst_hready_resp, dst_hresp, dst_hrdata,
    output src_hready_resp, src_hresp, src_hrdata,
           dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst,
           dst_hprot, dst_hmastlock, dst_hwdata
  );

  // Environment view: upstream masters and downstream slave
  modport master (
    output src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
           src_hprot, src_hmastlock, src_hwdata,
           dst_hready_resp, dst_hresp, dst_hrdata,
    input  src_hready_resp, src_hresp, src_hrdata,
           dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst,
           dst_hprot, dst_hmastlock, dst_hwdata
  );
endinterface

// File: rtl/ahbl_arbiter.sv
// Multi-master AHB-Lite arbiter: one-entry address buffer per upstream port, round-robin
// issue onto a single downstream port with hmastlock honoured, data phase routed by owner.
module ahbl_arbiter #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned W_ADDR  = 32,
  parameter int unsigned W_DATA  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  ahbl_arbiter_if.slave bus
);
  localparam int unsigned W_IDX = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef logic [W_IDX-1:0] idx_t;

  typedef struct packed {
    logic [W_ADDR-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic              hmastlock;
  } req_t;

  req_t               buf_q [N_PORTS];
  req_t               buf_d [N_PORTS];
  logic [N_PORTS-1:0] buf_valid_q, buf_valid_d;
  logic               data_valid_q, data_valid_d;
  idx_t               data_owner_q, data_owner_d;
  idx_t               last_q, last_d;
  logic               addr_locked_q, addr_locked_d;
  idx_t               addr_owner_q, addr_owner_d;
  logic               lock_held_q, lock_held_d;
  idx_t               lock_port_q, lock_port_d;

  logic [N_PORTS-1:0] cap_c;
  req_t               cap_req_c [N_PORTS];
  logic               pick_valid_c;
  idx_t               pick_c;
  logic               sel_valid_c;
  idx_t               sel_c;
  req_t               sel_req_c;
  logic [N_PORTS-1:0] hready_resp_c;
  logic [N_PORTS-1:0] hresp_c;
  logic [W_DATA-1:0]  hwdata_c;

  function automatic idx_t rr_idx(input idx_t base, input int unsigned off);
    return idx_t'((32'(base) + off) % N_PORTS);
  endfunction

  // Upstream address-phase capture; IDLE and BUSY have htrans[1]=0
  always_comb begin
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      cap_c[i]               = bus.src_htrans[2*i+1] & bus.src_hready[i];
      cap_req_c[i].haddr     = bus.src_haddr[i*W_ADDR +: W_ADDR];
      cap_req_c[i].hwrite    = bus.src_hwrite[i];
      cap_req_c[i].htrans    = bus.src_htrans[2*i +: 2];
      cap_req_c[i].hsize     = bus.src_hsize[3*i +: 3];
      cap_req_c[i].hburst    = bus.src_hburst[3*i +: 3];
      cap_req_c[i].hprot     = bus.src_hprot[4*i +: 4];
      cap_req_c[i].hmastlock = bus.src_hmastlock[i];
    end
  end

  // Round-robin pick starting after the last issued port; a held lock pins the pick
  always_comb begin
    pick_valid_c = 1'b0;
    pick_c       = '0;
    if (lock_held_q) begin
      pick_valid_c = buf_valid_q[lock_port_q];
      pick_c       = lock_port_q;
    end else begin
      for (int unsigned k = 1; k <= N_PORTS; k++) begin
        if (!pick_valid_c && buf_valid_q[rr_idx(last_q, k)]) begin
          pick_valid_c = 1'b1;
          pick_c       = rr_idx(last_q, k);
        end
      end
    end
  end

  // A stalled address phase keeps its owner until the slave accepts it
  assign sel_valid_c = addr_locked_q | pick_valid_c;
  assign sel_c       = addr_locked_q ? addr_owner_q : pick_c;
  assign sel_req_c   = sel_valid_c ? buf_q[sel_c] : '0;

  assign bus.dst_haddr     = sel_req_c.haddr;
  assign bus.dst_hwrite    = sel_req_c.hwrite;
  assign bus.dst_htrans    = sel_req_c.htrans;
  assign bus.dst_hsize     = sel_req_c.hsize;
  assign bus.dst_hburst    = sel_req_c.hburst;
  assign bus.dst_hprot     = sel_req_c.hprot;
  assign bus.dst_hmastlock = sel_req_c.hmastlock;
  assign bus.dst_hready    = bus.dst_hready_resp;

  // Next state: issue/hold on the downstream port, then upstream captures
  always_comb begin
    buf_valid_d   = buf_valid_q;
    data_valid_d  = data_valid_q;
    data_owner_d  = data_owner_q;
    last_d        = last_q;
    addr_locked_d = addr_locked_q;
    addr_owner_d  = addr_owner_q;
    lock_held_d   = lock_held_q;
    lock_port_d   = lock_port_q;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      buf_d[i] = buf_q[i];
    end

    if (bus.dst_hready_resp) begin
      if (sel_valid_c) begin
        buf_valid_d[sel_c] = 1'b0;
        data_valid_d       = 1'b1;
        data_owner_d       = sel_c;
        last_d             = sel_c;
        addr_locked_d      = 1'b0;
        lock_held_d        = sel_req_c.hmastlock;
        lock_port_d        = sel_c;
      end else begin
        data_valid_d = 1'b0;
      end
    end else if (sel_valid_c) begin
      addr_locked_d = 1'b1;
      addr_owner_d  = sel_c;
    end

    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (cap_c[i]) begin
        buf_valid_d[i] = 1'b1;
        buf_d[i]       = cap_req_c[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q   <= '0;
      data_valid_q  <= 1'b0;
      data_owner_q  <= '0;
      last_q        <= idx_t'(N_PORTS - 1);
      addr_locked_q <= 1'b0;
      addr_owner_q  <= '0;
      lock_held_q   <= 1'b0;
      lock_port_q   <= '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      buf_valid_q   <= buf_valid_d;
      data_valid_q  <= data_valid_d;
      data_owner_q  <= data_owner_d;
      last_q        <= last_d;
      addr_locked_q <= addr_locked_d;
      addr_owner_q  <= addr_owner_d;
      lock_held_q   <= lock_held_d;
      lock_port_q   <= lock_port_d;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  // Data-phase owner sees the slave; other ports stall only while their buffer is full
  always_comb begin
    hready_resp_c = ~buf_valid_q;
    hresp_c       = '0;
    hwdata_c      = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (data_valid_q && (data_owner_q == idx_t'(i))) begin
        hready_resp_c[i] = bus.dst_hready_resp;
        hresp_c[i]       = bus.dst_hresp;
        hwdata_c         = bus.src_hwdata[i*W_DATA +: W_DATA];
      end
    end
  end

  assign bus.src_hready_resp = hready_resp_c;
  assign bus.src_hresp       = hresp_c;
  assign bus.src_hrdata      = {N_PORTS{bus.dst_hrdata}};
  assign bus.dst_hwdata      = hwdata_c;

  a_capture_into_empty: assert property (
    @(posedge clk) disable iff (!rst_n) ((cap_c & buf_valid_q) == '0)
  );

endmodule

// File: tb/tb_ahbl_arbiter.sv
// Directed bench for ahbl_arbiter: reset, single read, contention, wait states, error, lock.
module tb_ahbl_arbiter;
  localparam int unsigned N_PORTS = 2;
  localparam int unsigned W_ADDR  = 32;
  localparam int unsigned W_DATA  = 32;

  logic clk;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  ahbl_arbiter_if #(.N_PORTS(N_PORTS), .W_ADDR(W_ADDR), .W_DATA(W_DATA)) bus ();

  ahbl_arbiter #(.N_PORTS(N_PORTS), .W_ADDR(W_ADDR), .W_DATA(W_DATA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Point-to-point upstream links: each master's hready is its own response
  assign bus.src_hready = bus.src_hready_resp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic wr, input logic lk);
    bus.src_htrans[p*2 +: 2]  = 2'b10;
    bus.src_haddr[p*32 +: 32] = a;
    bus.src_hwrite[p]         = wr;
    bus.src_hsize[p*3 +: 3]   = 3'b010;
    bus.src_hburst[p*3 +: 3]  = 3'b000;
    bus.src_hprot[p*4 +: 4]   = 4'b0011;
    bus.src_hmastlock[p]      = lk;
  endtask

  task automatic clr_req(input int p);
    bus.src_htrans[p*2 +: 2] = 2'b00;
    bus.src_hmastlock[p]     = 1'b0;
  endtask

  initial begin
    int          nidx [2];
    logic [1:0]  hr_prev;
    logic [1:0]  exp_hr;
    logic [31:0] exp_a;

    rst_n               = 1'b0;
    bus.src_haddr       = '0;
    bus.src_hwrite      = '0;
    bus.src_htrans      = '0;
    bus.src_hsize       = '0;
    bus.src_hburst      = '0;
    bus.src_hprot       = '0;
    bus.src_hmastlock   = '0;
    bus.src_hwdata      = '0;
    bus.dst_hready_resp = 1'b1;
    bus.dst_hresp       = 1'b0;
    bus.dst_hrdata      = '0;

    // Reset state
    step(); step(); #1;
    chk("rst_hready_resp", bus.src_hready_resp, 2'b11);
    chk("rst_hresp", bus.src_hresp, 2'b00);
    chk("rst_dst_htrans", bus.dst_htrans, 2'b00);
    chk("rst_dst_haddr", bus.dst_haddr, 32'h0);
    chk("rst_dst_hwdata", bus.dst_hwdata, 32'h0);

    // Contention from reset: issue order 0,1,0,1,...
    step();
    rst_n = 1'b1;
    set_req(0, 32'h1000_0000, 1'b0, 1'b0);
    set_req(1, 32'h2000_0000, 1'b0, 1'b0);
    nidx[0] = 0;
    nidx[1] = 0;
    #1;
    chk("cont_hready_c0", bus.src_hready_resp, 2'b11);
    hr_prev = 2'b11;
    for (int k = 0; k < 8; k++) begin
      step();
      for (int p = 0; p < 2; p++) begin
        if (hr_prev[p]) nidx[p]++;
        set_req(p, (p == 0 ? 32'h1000_0000 : 32'h2000_0000) + 32'(4 * nidx[p]), 1'b0, 1'b0);
      end
      #1;
      exp_a  = ((k % 2) == 0 ? 32'h1000_0000 : 32'h2000_0000) + 32'(4 * (k / 2));
      exp_hr = (k == 0) ? 2'b00 : (((k % 2) == 1) ? 2'b01 : 2'b10);
      chk($sformatf("cont_htrans_%0d", k), bus.dst_htrans, 2'b10);
      chk($sformatf("cont_haddr_%0d", k), bus.dst_haddr, exp_a);
      chk($sformatf("cont_hready_%0d", k), bus.src_hready_resp, exp_hr);
      hr_prev = exp_hr;
    end

    // Reset mid-transfer
    step();
    rst_n = 1'b0;
    clr_req(0);
    clr_req(1);
    #1;
    chk("midrst_hready", bus.src_hready_resp, 2'b11);
    chk("midrst_htrans", bus.dst_htrans, 2'b00);
    chk("midrst_hresp", bus.src_hresp, 2'b00);
    step(); #1;
    chk("midrst_hready_next", bus.src_hready_resp, 2'b11);
    chk("midrst_hwdata_next", bus.dst_hwdata, 32'h0);

    // Single read through a zero-wait slave
    step();
    rst_n = 1'b1;
    set_req(0, 32'h2008_0010, 1'b0, 1'b0);
    bus.dst_hrdata = 32'hdead_beef;
    #1;
    chk("rd_hready_cap", bus.src_hready_resp[0], 1'b1);
    step();
    clr_req(0);
    #1;
    chk("rd_dst_htrans", bus.dst_htrans, 2'b10);
    chk("rd_dst_haddr", bus.dst_haddr, 32'h2008_0010);
    chk("rd_dst_hwrite", bus.dst_hwrite, 1'b0);
    chk("rd_dst_hsize", bus.dst_hsize, 3'b010);
    chk("rd_dst_hprot", bus.dst_hprot, 4'b0011);
    chk("rd_hready_low", bus.src_hready_resp[0], 1'b0);
    step(); #1;
    chk("rd_hready_high", bus.src_hready_resp[0], 1'b1);
    chk("rd_hrdata", bus.src_hrdata[31:0], 32'hdead_beef);
    chk("rd_dst_idle", bus.dst_htrans, 2'b00);
    step(); #1;
    chk("rd_done_hready", bus.src_hready_resp, 2'b11);

    // Port 1 write held through three address-phase wait states
    set_req(1, 32'h4000_1000, 1'b1, 1'b0);
    #1;
    chk("ws_hready_cap", bus.src_hready_resp[1], 1'b1);
    for (int j = 0; j < 4; j++) begin
      step();
      clr_req(1);
      bus.src_hwdata[63:32] = 32'h1234_5678;
      bus.dst_hready_resp   = (j == 3);
      #1;
      chk($sformatf("ws_haddr_%0d", j), bus.dst_haddr, 32'h4000_1000);
      chk($sformatf("ws_htrans_%0d", j), bus.dst_htrans, 2'b10);
      chk($sformatf("ws_hwrite_%0d", j), bus.dst_hwrite, 1'b1);
      chk($sformatf("ws_hready1_%0d", j), bus.src_hready_resp[1], 1'b0);
    end
    step();
    bus.dst_hready_resp = 1'b0;
    #1;
    chk("ws_hwdata_wait", bus.dst_hwdata, 32'h1234_5678);
    chk("ws_hready1_wait", bus.src_hready_resp[1], 1'b0);
    step();
    bus.dst_hready_resp = 1'b1;
    #1;
    chk("ws_hwdata_done", bus.dst_hwdata, 32'h1234_5678);
    chk("ws_hready1_done", bus.src_hready_resp[1], 1'b1);
    step(); #1;
    chk("ws_hwdata_after", bus.dst_hwdata, 32'h0);

    // Two-cycle ERROR on port 0; a transfer captured in the second cycle still issues
    set_req(0, 32'h3000_0000, 1'b0, 1'b0);
    step();
    clr_req(0);
    #1;
    chk("err_dst_haddr", bus.dst_haddr, 32'h3000_0000);
    step();
    bus.dst_hresp       = 1'b1;
    bus.dst_hready_resp = 1'b0;
    #1;
    chk("err1_hresp", bus.src_hresp, 2'b01);
    chk("err1_hready0", bus.src_hready_resp[0], 1'b0);
    step();
    bus.dst_hready_resp = 1'b1;
    set_req(0, 32'h3000_0004, 1'b0, 1'b0);
    #1;
    chk("err2_hresp", bus.src_hresp, 2'b01);
    chk("err2_hready0", bus.src_hready_resp[0], 1'b1);
    step();
    bus.dst_hresp = 1'b0;
    clr_req(0);
    #1;
    chk("err_next_htrans", bus.dst_htrans, 2'b10);
    chk("err_next_haddr", bus.dst_haddr, 32'h3000_0004);
    chk("err_next_hresp", bus.src_hresp, 2'b00);
    step(); #1;
    chk("err_next_done", bus.src_hready_resp[0], 1'b1);

    // Locked sequence on port 0 keeps port 1 out until the unlocked transfer is accepted
    step();
    set_req(0, 32'h5000_0000, 1'b0, 1'b1);
    #1;
    chk("lk_hready_cap", bus.src_hready_resp[0], 1'b1);
    step();
    set_req(0, 32'h5000_0004, 1'b0, 1'b1);
    set_req(1, 32'h6000_0000, 1'b0, 1'b0);
    #1;
    chk("lk_l0_haddr", bus.dst_haddr, 32'h5000_0000);
    chk("lk_l0_lock", bus.dst_hmastlock, 1'b1);
    chk("lk_l0_hready", bus.src_hready_resp, 2'b10);
    step();
    clr_req(1);
    #1;
    chk("lk_gap1_htrans", bus.dst_htrans, 2'b00);
    chk("lk_gap1_hready", bus.src_hready_resp, 2'b01);
    step();
    set_req(0, 32'h5000_0008, 1'b0, 1'b0);
    #1;
    chk("lk_l1_htrans", bus.dst_htrans, 2'b10);
    chk("lk_l1_haddr", bus.dst_haddr, 32'h5000_0004);
    chk("lk_l1_lock", bus.dst_hmastlock, 1'b1);
    chk("lk_l1_hready", bus.src_hready_resp, 2'b00);
    step(); #1;
    chk("lk_gap2_htrans", bus.dst_htrans, 2'b00);
    chk("lk_gap2_hready", bus.src_hready_resp, 2'b01);
    step();
    clr_req(0);
    #1;
    chk("lk_l2_htrans", bus.dst_htrans, 2'b10);
    chk("lk_l2_haddr", bus.dst_haddr, 32'h5000_0008);
    chk("lk_l2_lock", bus.dst_hmastlock, 1'b0);
    step(); #1;
    chk("lk_p1_htrans", bus.dst_htrans, 2'b10);
    chk("lk_p1_haddr", bus.dst_haddr, 32'h6000_0000);
    chk("lk_p1_hready", bus.src_hready_resp, 2'b01);
    step(); #1;
    chk("lk_p1_done", bus.src_hready_resp, 2'b11);
    chk("lk_p1_idle", bus.dst_htrans, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
